// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Imported by the top level and the per-channel holding register.
package dmux_pkg;

    localparam int DMUX_MAX_CH     = 16;
    localparam int DMUX_DATA_W_DEF = 8;

    // Select width needed for n channels, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmux_ch_reg.sv
// One-entry valid/ready holding register for a single output channel.
// Pop and refill may happen on the same edge.
module dmux_ch_reg
    import dmux_pkg::*;
#(
    parameter int DATA_W = DMUX_DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // A load wins over a pop, so a same-edge pop/refill keeps valid high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_free  = ~r_valid | i_ready;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-NUM_CH stream demultiplexer with unicast, broadcast and
// a saturating counter of words dropped for an out-of-range select.
module dmux_stream
    import dmux_pkg::*;
#(
    parameter int DATA_W = DMUX_DATA_W_DEF,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2_min1(NUM_CH),
    parameter int ERR_W  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_s_valid,
    output logic                     o_s_ready,
    input  logic [DATA_W-1:0]        i_s_data,
    input  logic [SEL_W-1:0]         i_s_sel,
    input  logic                     i_s_bcast,
    output logic [NUM_CH-1:0]        o_m_valid,
    input  logic [NUM_CH-1:0]        i_m_ready,
    output logic [NUM_CH*DATA_W-1:0] o_m_data,
    output logic [ERR_W-1:0]         o_err_cnt
);

    logic [NUM_CH-1:0] w_sel_hit;
    logic [NUM_CH-1:0] w_free;
    logic [NUM_CH-1:0] w_load;
    logic              w_sel_bad;
    logic              w_sel_free;
    logic              w_all_free;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_drop;
    logic [ERR_W-1:0]  r_err_cnt;

    // Decoding by equality keeps unused select codes (NUM_CH not a power of two) as "bad".
    always_comb begin
        w_sel_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sel_hit[k] = (i_s_sel == SEL_W'(k));
        end
    end

    assign w_sel_bad  = ~|w_sel_hit;
    assign w_sel_free = |(w_sel_hit & w_free);
    assign w_all_free = &w_free;

    always_comb begin
        w_s_ready = 1'b0;
        if (i_rst_n && i_en) begin
            if (i_s_bcast) begin
                w_s_ready = w_all_free;
            end else if (w_sel_bad) begin
                w_s_ready = 1'b1;
            end else begin
                w_s_ready = w_sel_free;
            end
        end
    end

    assign w_accept = i_s_valid & w_s_ready;
    assign w_drop   = w_accept & ~i_s_bcast & w_sel_bad;

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load = i_s_bcast ? {NUM_CH{1'b1}} : w_sel_hit;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dmux_ch_reg #(
            .DATA_W (DATA_W)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (w_load[g]),
            .i_data  (i_s_data),
            .i_ready (i_m_ready[g]),
            .o_valid (o_m_valid[g]),
            .o_data  (o_m_data[g*DATA_W +: DATA_W]),
            .o_free  (w_free[g])
        );
    end

    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (w_drop && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_s_ready = w_s_ready;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: a 4-channel instance with a data scoreboard and a
// 3-channel instance for out-of-range select handling.
module tb_dmux_stream;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [1:0]  s_sel;
    logic        s_bcast;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [31:0] m_data;
    logic [7:0]  err_cnt;

    logic        b_en;
    logic        b_s_valid;
    logic        b_s_ready;
    logic [7:0]  b_s_data;
    logic [1:0]  b_s_sel;
    logic        b_s_bcast;
    logic [2:0]  b_m_valid;
    logic [2:0]  b_m_ready;
    logic [23:0] b_m_data;
    logic [7:0]  b_err_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [4][$];

    dmux_stream #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .ERR_W(8)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .i_s_sel(s_sel), .i_s_bcast(s_bcast),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_err_cnt(err_cnt)
    );

    dmux_stream #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .ERR_W(8)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en),
        .i_s_valid(b_s_valid), .o_s_ready(b_s_ready), .i_s_data(b_s_data),
        .i_s_sel(b_s_sel), .i_s_bcast(b_s_bcast),
        .o_m_valid(b_m_valid), .i_m_ready(b_m_ready), .o_m_data(b_m_data),
        .o_err_cnt(b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: accepted words are queued per channel and compared on pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) q[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_valid[k] && m_ready[k]) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL pop_ch%0d: got data %h, expected no word", k, m_data[k*8 +: 8]);
                    end else begin
                        logic [7:0] exp;
                        exp = q[k].pop_front();
                        if (m_data[k*8 +: 8] !== exp) begin
                            errors++;
                            $display("[TB] FAIL pop_ch%0d: got %h, expected %h", k, m_data[k*8 +: 8], exp);
                        end
                    end
                end
            end
            if (s_valid && s_ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (s_bcast || (s_sel == k)) q[k].push_back(s_data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; s_sel = '0; s_bcast = 1'b0; m_ready = '0;
        b_en = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_s_sel = '0; b_s_bcast = 1'b0; b_m_ready = '0;
        tick(); tick();
        en = 1'b1; b_en = 1'b1;
        #1;
        checks++;
        if (m_valid !== 4'h0 || m_data !== 32'h0 || err_cnt !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: m_valid=%h m_data=%h err=%h, expected all zero", m_valid, m_data, err_cnt);
        end
        checks++;
        if (s_ready !== 1'b0 || b_s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: s_ready=%b/%b, expected 0 during reset", s_ready, b_s_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unicast();
        m_ready = 4'hF; s_valid = 1'b1; s_data = 8'hA5; s_bcast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_sel = 2'(i);
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL unicast_ready%0d: got %b, expected 1", i, s_ready);
            end
            tick();
            checks++;
            if (m_valid !== (4'b0001 << i) || m_data[i*8 +: 8] !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL unicast_ch%0d: m_valid=%b data=%h, expected %b / a5", i, m_valid, m_data[i*8 +: 8], 4'b0001 << i);
            end
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if (m_valid !== 4'h0) begin
            errors++;
            $display("[TB] FAIL unicast_drain: m_valid=%b, expected 0000", m_valid);
        end
    endtask

    task automatic test_stall();
        m_ready = 4'b1101; s_valid = 1'b1; s_sel = 2'd1; s_data = 8'h11;
        tick();
        s_data = 8'h22;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_ready: got %b, expected 0", s_ready);
        end
        tick(); tick();
        checks++;
        if (m_valid[1] !== 1'b1 || m_data[15:8] !== 8'h11) begin
            errors++;
            $display("[TB] FAIL stall_hold: valid=%b data=%h, expected 1 / 11", m_valid[1], m_data[15:8]);
        end
        m_ready[1] = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got %b, expected 1", s_ready);
        end
        tick();
        checks++;
        if (m_valid[1] !== 1'b1 || m_data[15:8] !== 8'h22) begin
            errors++;
            $display("[TB] FAIL pop_refill: valid=%b data=%h, expected 1 / 22", m_valid[1], m_data[15:8]);
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if (m_valid[1] !== 1'b0 || m_data[15:8] !== 8'h22) begin
            errors++;
            $display("[TB] FAIL pop_keep_data: valid=%b data=%h, expected 0 / 22", m_valid[1], m_data[15:8]);
        end
    endtask

    task automatic test_bcast();
        m_ready = 4'b1011; s_valid = 1'b1; s_bcast = 1'b0; s_sel = 2'd2; s_data = 8'h77;
        tick();
        s_bcast = 1'b1; s_data = 8'h3C;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bcast_blocked: s_ready=%b, expected 0", s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 4'b0100 || m_data[23:16] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL bcast_wait: m_valid=%b ch2=%h, expected 0100 / 77", m_valid, m_data[23:16]);
        end
        m_ready = 4'hF;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bcast_ready: s_ready=%b, expected 1", s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 4'hF || m_data !== 32'h3C3C3C3C) begin
            errors++;
            $display("[TB] FAIL bcast_load: m_valid=%b m_data=%h, expected 1111 / 3c3c3c3c", m_valid, m_data);
        end
        s_valid = 1'b0; s_bcast = 1'b0;
        tick();
    endtask

    task automatic test_bad_sel();
        int exp_err;
        int bad_ready;
        int bad_valid;
        exp_err = 0; bad_ready = 0; bad_valid = 0;
        b_m_ready = 3'b000; b_s_valid = 1'b1; b_s_sel = 2'b11; b_s_bcast = 1'b0;
        for (int n = 0; n < 300; n++) begin
            b_s_data = 8'(n);
            #1;
            if (b_s_ready !== 1'b1) bad_ready++;
            tick();
            if (exp_err < 255) exp_err++;
            if (b_m_valid !== 3'b000) bad_valid++;
            checks++;
            if (b_err_cnt !== 8'(exp_err)) begin
                errors++;
                $display("[TB] FAIL err_cnt_%0d: got %h, expected %h", n, b_err_cnt, 8'(exp_err));
            end
        end
        b_s_valid = 1'b0;
        checks++;
        if (bad_ready != 0 || bad_valid != 0) begin
            errors++;
            $display("[TB] FAIL bad_sel_flow: not-ready cycles=%0d valid cycles=%0d, expected 0 and 0", bad_ready, bad_valid);
        end
        checks++;
        if (b_err_cnt !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL err_saturate: got %h, expected ff", b_err_cnt);
        end
    endtask

    task automatic test_enable();
        m_ready = 4'h0; en = 1'b1; s_valid = 1'b1; s_sel = 2'd0; s_data = 8'h5A;
        tick();
        en = 1'b0; s_data = 8'h66;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enable_ready: got %b, expected 0", s_ready);
        end
        tick();
        checks++;
        if (m_valid[0] !== 1'b1 || m_data[7:0] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL enable_hold: valid=%b data=%h, expected 1 / 5a", m_valid[0], m_data[7:0]);
        end
        m_ready[0] = 1'b1;
        tick();
        checks++;
        if (m_valid[0] !== 1'b0 || m_data[7:0] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL enable_drain: valid=%b data=%h, expected 0 / 5a", m_valid[0], m_data[7:0]);
        end
        s_valid = 1'b0; en = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] sels [3];
        sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd3;
        m_ready = 4'b1011; s_valid = 1'b1; s_sel = 2'd2; s_data = 8'hC7;
        tick();
        for (int i = 0; i < 9; i++) begin
            s_sel = sels[i % 3];
            s_data = 8'($urandom_range(0, 255));
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready%0d: got %b, expected 1 with ch2 stalled", i, s_ready);
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 4'hF;
        tick(); tick();
        checks++;
        if (m_valid !== 4'h0 || q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0 || q[3].size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: m_valid=%b queue sizes %0d %0d %0d %0d, expected all empty",
                     m_valid, q[0].size(), q[1].size(), q[2].size(), q[3].size());
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        b_m_ready = 3'b000; b_s_valid = 1'b1; b_s_sel = 2'b11;
        m_ready = 4'h0; s_valid = 1'b1; s_bcast = 1'b1; s_data = 8'h99;
        tick();
        s_valid = 1'b0; s_bcast = 1'b0;
        tick(); tick(); tick(); tick();
        b_s_valid = 1'b0;
        checks++;
        if (m_valid !== 4'hF || b_err_cnt !== 8'd5) begin
            errors++;
            $display("[TB] FAIL reset_setup: m_valid=%b err=%0d, expected 1111 / 5", m_valid, b_err_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0 || b_s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_ready: s_ready=%b/%b, expected 0", s_ready, b_s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 4'h0 || m_data !== 32'h0 || b_err_cnt !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_state: m_valid=%b m_data=%h err=%h, expected 0 / 0 / 0", m_valid, m_data, b_err_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_stall();
        test_bcast();
        test_bad_sel();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
